// File: rtl/panda_pkg.sv
// Shared types and constants for the panda data-memory responder.
package panda_pkg;

    localparam int DMEM_LAT_W = 4;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    // Value loaded into the wait counter on accept; LATENCY==0 never enters WAIT.
    function automatic logic [DMEM_LAT_W-1:0] dmem_wait_load(input int unsigned latency);
        logic [DMEM_LAT_W-1:0] load;
        if (latency == 0) begin
            load = {DMEM_LAT_W{1'b0}};
        end else begin
            load = DMEM_LAT_W'(latency - 1);
        end
        return load;
    endfunction

endpackage

// File: rtl/panda_dmem_ram.sv
// Single-port DEPTH_WORDS x 32 data array with byte-lane write enables and a registered read port.
module panda_dmem_ram
    import panda_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    we_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Array write per byte lane and registered read; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/panda_dmem_responder.sv
// Memory-side responder for the core data interface: FSM, latency counter, range check, response registers.
// Optional feature macro: PANDA_DMEM_ERR_EN (out-of-range error responses instead of address aliasing).
module panda_dmem_responder
    import panda_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic [3:0]  data_we_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [DMEM_LAT_W-1:0] WAIT_LOAD = dmem_wait_load(LATENCY);

    dmem_state_e           state_q, state_d;
    logic [DMEM_LAT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic                  wr_q, wr_d;
    logic                  err_pend_q, err_pend_d;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;
    logic                  rsel_q, rsel_d;

    logic [31:0]   offset_s;
    logic [29:0]   idx_full_s;
    logic [AW-1:0] idx_s;
    logic          oor_s;
    logic          unused_s;
    logic          gnt_s;
    logic          accept_s;
    logic [3:0]    ram_we_s;
    logic [AW-1:0] ram_addr_s;
    logic          ram_re_s;
    logic [31:0]   ram_rdata_s;

    // Word index relative to BASE_ADDR, modulo 2^32.
    assign offset_s   = data_addr_i - BASE_ADDR;
    assign idx_full_s = offset_s[31:2];
    assign idx_s      = idx_full_s[AW-1:0];

`ifdef PANDA_DMEM_ERR_EN
    assign oor_s    = (idx_full_s >= 30'(DEPTH_WORDS));
    assign unused_s = ^offset_s[1:0];
`else
    assign oor_s    = 1'b0;
    assign unused_s = ^{offset_s[1:0], idx_full_s[29:AW]};
`endif

    assign gnt_s    = ((state_q == DMEM_IDLE) || (state_q == DMEM_RESP)) && !rst_i;
    assign accept_s = data_req_i && gnt_s;

    // Next-state, latency counter and captured request attributes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = accept_s ? idx_s : idx_q;
        wr_d       = accept_s ? (|data_we_i) : wr_q;
        err_pend_d = accept_s ? oor_s : err_pend_q;
        case (state_q)
            DMEM_IDLE, DMEM_RESP: begin
                if (accept_s) begin
                    if (LATENCY == 0) begin
                        state_d = DMEM_RESP;
                    end else begin
                        state_d = DMEM_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end else begin
                    state_d = DMEM_IDLE;
                end
            end
            DMEM_WAIT: begin
                if (cnt_q == {DMEM_LAT_W{1'b0}}) begin
                    state_d = DMEM_RESP;
                end else begin
                    cnt_d = cnt_q - DMEM_LAT_W'(1);
                end
            end
            default: begin
                state_d = DMEM_IDLE;
                cnt_d   = {DMEM_LAT_W{1'b0}};
            end
        endcase
        rvalid_d = (state_d == DMEM_RESP);
        err_d    = rvalid_d && err_pend_d;
        rsel_d   = rvalid_d && !wr_d && !err_pend_d;
    end

    // On the accept edge the RAM sees the incoming index; afterwards the latched one.
    assign ram_addr_s = accept_s ? idx_s : idx_q;
    assign ram_we_s   = (accept_s && !oor_s) ? data_we_i : 4'b0000;
    assign ram_re_s   = rsel_d && !rst_i;

    // State and response registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= DMEM_IDLE;
            cnt_q      <= {DMEM_LAT_W{1'b0}};
            idx_q      <= {AW{1'b0}};
            wr_q       <= 1'b0;
            err_pend_q <= 1'b0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rsel_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wr_q       <= wr_d;
            err_pend_q <= err_pend_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            rsel_q     <= rsel_d;
        end
    end

    panda_dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .addr_i  (ram_addr_s),
        .we_i    (ram_we_s),
        .wdata_i (data_wdata_i),
        .re_i    (ram_re_s),
        .rdata_o (ram_rdata_s)
    );

    assign data_gnt_o    = gnt_s;
    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rsel_q ? ram_rdata_s : 32'h0000_0000;
    assign data_err_o    = err_q;

endmodule

// File: tb/tb_panda_dmem_responder.sv
// Directed bench for panda_dmem_responder: three instances at LATENCY 1, 0 and 3 sharing clock and reset.
module tb_panda_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req   [3];
    logic [31:0] addr  [3];
    logic [3:0]  we    [3];
    logic [31:0] wdata [3];
    logic        gnt   [3];
    logic        rvalid[3];
    logic [31:0] rdata [3];
    logic        err   [3];

    int checks   = 0;
    int failures = 0;
    int lat_of [3] = '{1, 0, 3};

    typedef struct {
        int          s;
        logic [31:0] a;
        logic [3:0]  w;
        logic [31:0] d;
        logic [31:0] er;
        logic        ee;
    } vec_t;

    vec_t        tbl [$];
    logic [31:0] exp_seq [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    panda_dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0)) u_lat1 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req[0]), .data_gnt_o(gnt[0]),
        .data_addr_i(addr[0]), .data_we_i(we[0]), .data_wdata_i(wdata[0]),
        .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]), .data_err_o(err[0]));

    panda_dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0), .BASE_ADDR(32'h0)) u_lat0 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req[1]), .data_gnt_o(gnt[1]),
        .data_addr_i(addr[1]), .data_we_i(we[1]), .data_wdata_i(wdata[1]),
        .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1]));

    panda_dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3), .BASE_ADDR(32'h0)) u_lat3 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req[2]), .data_gnt_o(gnt[2]),
        .data_addr_i(addr[2]), .data_we_i(we[2]), .data_wdata_i(wdata[2]),
        .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]), .data_err_o(err[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // One request: wait (bounded) for grant, then check the response window cycle by cycle.
    task automatic do_req(input string nm, input int s, input logic [31:0] a, input logic [3:0] w,
                          input logic [31:0] d, input logic [31:0] er, input logic ee);
        bit got;
        int lat;
        lat = lat_of[s];
        got = 1'b0;
        @(posedge clk); #1;
        req[s] = 1'b1; addr[s] = a; we[s] = w; wdata[s] = d;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (gnt[s]) got = 1'b1;
        end
        if (!got) begin
            chk({nm, "_gnt_timeout"}, 32'd0, 32'd1);
            req[s] = 1'b0;
        end else begin
            @(posedge clk); #1;
            req[s] = 1'b0; we[s] = 4'h0;
            for (int k = 1; k <= lat + 2; k++) begin
                @(negedge clk);
                chk($sformatf("%s_rvalid_c%0d", nm, k), {31'd0, rvalid[s]}, {31'd0, (k == lat + 1)});
                if (k <= lat) chk($sformatf("%s_gnt_wait_c%0d", nm, k), {31'd0, gnt[s]}, 32'd0);
                if (k == lat + 1) begin
                    chk({nm, "_rdata"}, rdata[s], er);
                    chk({nm, "_err"}, {31'd0, err[s]}, {31'd0, ee});
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; addr[i] = 32'h0; we[i] = 4'h0; wdata[i] = 32'h0;
        end

        // Test 1/2/6 on LATENCY=1, byte lanes on LATENCY=3, preload for the LATENCY=0 burst.
        tbl.push_back('{0, 32'h10,   4'hF, 32'h0000000A, 32'h0,        1'b0});
        tbl.push_back('{0, 32'h10,   4'h0, 32'h0,        32'h0000000A, 1'b0});
        tbl.push_back('{0, 32'h14,   4'hF, 32'hFFFFFFFF, 32'h0,        1'b0});
        tbl.push_back('{0, 32'h14,   4'hC, 32'hABCD0000, 32'h0,        1'b0});
        tbl.push_back('{0, 32'h14,   4'h0, 32'h0,        32'hABCDFFFF, 1'b0});
        tbl.push_back('{0, 32'h0,    4'hF, 32'h11111111, 32'h0,        1'b0});
`ifdef PANDA_DMEM_ERR_EN
        tbl.push_back('{0, 32'h1000, 4'hF, 32'hDEADBEEF, 32'h0,        1'b1});
        tbl.push_back('{0, 32'h0,    4'h0, 32'h0,        32'h11111111, 1'b0});
        tbl.push_back('{0, 32'h1000, 4'h0, 32'h0,        32'h0,        1'b1});
`else
        tbl.push_back('{0, 32'h1000, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0});
        tbl.push_back('{0, 32'h0,    4'h0, 32'h0,        32'hDEADBEEF, 1'b0});
        tbl.push_back('{0, 32'h1000, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0});
`endif
        tbl.push_back('{2, 32'h40,   4'hF, 32'h12345678, 32'h0,        1'b0});
        tbl.push_back('{2, 32'h40,   4'h3, 32'h00005A5A, 32'h0,        1'b0});
        tbl.push_back('{2, 32'h40,   4'h4, 32'h00FF0000, 32'h0,        1'b0});
        tbl.push_back('{2, 32'h42,   4'h0, 32'h0,        32'h12FF5A5A, 1'b0});
        tbl.push_back('{1, 32'h0,    4'hF, 32'h00000100, 32'h0,        1'b0});
        tbl.push_back('{1, 32'h4,    4'hF, 32'h00000104, 32'h0,        1'b0});
        tbl.push_back('{1, 32'h8,    4'hF, 32'h00000108, 32'h0,        1'b0});
        tbl.push_back('{1, 32'hC,    4'hF, 32'h0000010C, 32'h0,        1'b0});
        exp_seq = '{32'h00000100, 32'h00000104, 32'h00000108, 32'h0000010C};

        // Reset state: outputs cleared and grant suppressed while reset is high.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_gnt%0d", i),    {31'd0, gnt[i]},    32'd0);
            chk($sformatf("rst_rvalid%0d", i), {31'd0, rvalid[i]}, 32'd0);
            chk($sformatf("rst_rdata%0d", i),  rdata[i],           32'd0);
            chk($sformatf("rst_err%0d", i),    {31'd0, err[i]},    32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_gnt", {31'd0, gnt[0]}, 32'd1);

        foreach (tbl[v]) begin
            do_req($sformatf("vec%0d", v), tbl[v].s, tbl[v].a, tbl[v].w, tbl[v].d, tbl[v].er, tbl[v].ee);
        end

        // LATENCY=0 back-to-back reads with req held: grant every cycle, one rvalid per cycle.
        @(posedge clk); #1;
        req[1] = 1'b1; addr[1] = 32'h0; we[1] = 4'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("burst_gnt%0d", i), {31'd0, gnt[1]}, 32'd1);
            chk($sformatf("burst_rvalid%0d", i), {31'd0, rvalid[1]}, {31'd0, (i > 0)});
            if (i > 0) chk($sformatf("burst_rdata%0d", i), rdata[1], exp_seq[i-1]);
            @(posedge clk); #1;
            if (i < 3) addr[1] = 32'(4 * (i + 1));
            else req[1] = 1'b0;
        end
        @(negedge clk);
        chk("burst_rvalid_end", {31'd0, rvalid[1]}, 32'd0);

        // Reset during WAIT: response dropped, committed write survives.
        @(posedge clk); #1;
        req[2] = 1'b1; addr[2] = 32'h20; we[2] = 4'hF; wdata[2] = 32'h12345678;
        @(negedge clk);
        chk("rstwait_gnt", {31'd0, gnt[2]}, 32'd1);
        @(posedge clk); #1;
        req[2] = 1'b0; we[2] = 4'h0;
        @(negedge clk);
        chk("rstwait_in_wait", {31'd0, gnt[2]}, 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("rstwait_no_rvalid%0d", k), {31'd0, rvalid[2]}, 32'd0);
        end
        do_req("rstwait_read", 2, 32'h20, 4'h0, 32'h0, 32'h12345678, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
